// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared types and constants for the doodle pin scanner.
package doodle_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SETTLE
  } state_t;

endpackage

// File: rtl/pin_sync_edge.sv
// rtl/pin_sync_edge.sv - N-stage input synchroniser with level and rise/fall pulses.
module pin_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Chain resets low so a cs_n already held low after reset never looks like a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/doodle_pin_scanner.sv
// rtl/doodle_pin_scanner.sv - serial-to-pin driver that applies a byte, settles, and
// samples the doodle response for return during the next byte.
module doodle_pin_scanner
  import doodle_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic [BYTE_W-1:0] dut_ui_o,
  input  logic [BYTE_W-1:0] dut_uo_i,
  output logic              busy_o,
  output logic              ovr_o,
  output logic [7:0]        frame_cnt_o
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [BYTE_W-1:0] rx_sr_q, tx_sr_q, capture_q;
  logic [3:0]        settle_cnt_q;

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;
  logic bit_take, byte_done, capture_now;

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk_i),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n_i),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi_i),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  always_comb begin
    state_d     = state_q;
    bit_take    = 1'b0;
    byte_done   = 1'b0;
    capture_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          bit_take = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            state_d   = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!cs_rise && sclk_rise) begin
          bit_take  = 1'b1;
          byte_done = (bit_cnt_q == 3'd7);
        end
        // A fresh byte restarts settling and wins over a capture due this cycle.
        if (!byte_done && settle_cnt_q == 4'd0) begin
          capture_now = 1'b1;
          state_d     = cs_level ? IDLE : SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      capture_q    <= '0;
      settle_cnt_q <= '0;
      dut_ui_o     <= '0;
      ovr_o        <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        bit_cnt_q <= '0;
        tx_sr_q   <= capture_q;
      end else begin
        if (state_q == SHIFT && cs_rise) begin
          bit_cnt_q <= '0;
        end else if (bit_take) begin
          rx_sr_q   <= {rx_sr_q[BYTE_W-2:0], mosi_level};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end

        if (byte_done) begin
          dut_ui_o     <= {rx_sr_q[BYTE_W-2:0], mosi_level};
          settle_cnt_q <= SETTLE_LOAD;
          if (state_q == SETTLE) ovr_o <= 1'b1;
        end else if (state_q == SETTLE && settle_cnt_q != 4'd0) begin
          settle_cnt_q <= settle_cnt_q - 4'd1;
        end

        // The fall trailing the 8th rise (bit_cnt back at 0) must not eat the next MSB.
        if (capture_now) begin
          capture_q   <= dut_uo_i;
          tx_sr_q     <= dut_uo_i;
          frame_cnt_o <= frame_cnt_o + 8'd1;
          if (bit_cnt_q != 3'd0) ovr_o <= 1'b1;
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
          tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

  assign busy_o = (state_q != IDLE);
  assign miso_o = busy_o & tx_sr_q[BYTE_W-1];

endmodule
